vga_capture: RTL and testbench
==============================

// Module: vga_capture
// PURPOSE
// - Receiving end of the VGA output stream (VGA_HSYNC/VGA_VSYNC/VGA_RGB).
// - Decodes sync, measures line/frame timing and locks to the expected mode.
// - Emits per-pixel X/Y/RGB for the active area.
// - Used as an on-chip loopback monitor for scan-converter self-test, and as a bench checker.
// PARAMETERS
// H_TOTAL     800  expected PIX_en samples per line (HS rise to HS rise)
// V_TOTAL     525  expected lines per frame (VS rise to VS rise)
// H_START     144  hpos of first active pixel (hpos 0 = sample with HS rise)
// H_ACTIVE    640  active pixels per line
// V_START     35   vpos of first active line (vpos 0 = line containing VS rise)
// V_ACTIVE    480  active lines per frame
// LOCK_FRAMES 2    consecutive clean frames needed to lock (1..15)
// PORTS
// CLK         in   1   system clock
// nRESET      in   1   asynchronous active-low reset
// PIX_en      in   1   pixel-rate enable; all sampling and counting happens only on CLK edges with PIX_en=1
// VGA_HSYNC   in   1   horizontal sync, active high
// VGA_VSYNC   in   1   vertical sync, active high
// VGA_RGB     in   3   pixel colour {R,G,B}
// PIX_X       out  10  active-area column 0..H_ACTIVE-1
// PIX_Y       out  10  active-area row 0..V_ACTIVE-1
// PIX_RGB     out  3   captured colour
// PIX_VALID   out  1   one-CLK strobe: PIX_X/Y/RGB valid
// LINE_LEN    out  11  last measured line length (samples)
// FRAME_LINES out  10  last measured frame length (lines)
// LOCKED      out  1   timing matches H_TOTAL/V_TOTAL
// SYNC_ERR    out  1   one-CLK strobe: timing violation detected while LOCKED
// FRAME_CRC   out  16  CRC of last frame's active pixels (see CONFIGURATION)
// CRC_VALID   out  1   one-CLK strobe: FRAME_CRC updated
// BEHAVIOUR
// - Reset: all outputs, counters and sync history 0; FSM = UNLOCKED.
// - Edge detect: HS_RISE = VGA_HSYNC & ~hs_q; VS_RISE = VGA_VSYNC & ~vs_q. hs_q/vs_q update on PIX_en.
// - hpos (11 b): HS_RISE ? 0 : HCNT+1, saturating at 2047. HCNT <= hpos.
//   On HS_RISE: LINE_LEN <= HCNT+1.
// - vpos (10 b): VS_RISE ? 0 : HS_RISE ? VCNT+1 (sat 1023) : VCNT. VCNT <= vpos.
//   VS_RISE wins over a simultaneous HS_RISE.
// - LCNT counts HS_RISE. On VS_RISE: FRAME_LINES <= LCNT + HS_RISE; LCNT <= 0.
//   A simultaneous HS rise counts toward the ending frame.
// - Active sample: H_START <= hpos < H_START+H_ACTIVE, V_START <= vpos < V_START+V_ACTIVE, and LOCKED.
//   Registered output, 1 CLK latency.
//   PIX_VALID=1 on the next CLK, with PIX_X=hpos-H_START, PIX_Y=vpos-V_START, PIX_RGB=VGA_RGB.
//   PIX_VALID=0 on every other CLK, including CLKs with PIX_en=0.
// - Error condition (evaluated on PIX_en):
//   (a) HS_RISE and HCNT+1 != H_TOTAL, or
//   (b) VS_RISE and LCNT+HS_RISE != V_TOTAL, or
//   (c) HCNT reaches 2047 (lost hsync).
// - FSM:
//   UNLOCKED: no checks. VS_RISE -> TRACK, good=0.
//   TRACK:    error -> UNLOCKED.
//             VS_RISE without error: good+1; if good+1==LOCK_FRAMES -> LOCKED.
//   LOCKED:   error -> UNLOCKED, SYNC_ERR=1 for one CLK.
//             The sample raising the error produces no PIX_VALID.
// - LOCKED is 1 exactly in state LOCKED.
// - Reset mid-frame discards all history; relock requires a VS_RISE plus LOCK_FRAMES clean frames.
// CONFIGURATION
// - Macro VGA_CAPTURE_CRC_EN.
// - Defined:
//   - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) over each active sample's 3 bits, R first.
//   - On VS_RISE while LOCKED: FRAME_CRC <= crc; CRC_VALID=1 for one CLK.
//   - The running crc is re-initialised to 0xFFFF on every VS_RISE.
//   - No update while not LOCKED.
// - Undefined: FRAME_CRC=0, CRC_VALID=0, no CRC logic.
// TESTING
// 1. nRESET low mid-line with PIX_en=1 -> all outputs 0 asynchronously; LOCKED stays 0 until 3rd VS_RISE after release.
// 2. Clean 800x525 timing, HS width 96, LOCK_FRAMES=2 -> LOCKED rises on the 3rd VS_RISE; LINE_LEN=800, FRAME_LINES=525.
// 3. Locked; RGB=3'b101 at hpos=154, vpos=37 -> next CLK PIX_VALID=1, PIX_X=10, PIX_Y=2, PIX_RGB=5; count 307200 strobes/frame.
// 4. Locked; one line of 799 samples -> SYNC_ERR pulse at that HS_RISE, LINE_LEN=799, LOCKED=0, PIX_VALID=0 until relock.
// 5. Locked; HSYNC held low -> HCNT saturates at 2047 -> SYNC_ERR pulse, LOCKED=0.
// 6. CRC_EN: two identical frames -> equal FRAME_CRC; flip one pixel 0->7 -> FRAME_CRC differs; PIX_en=0 for 5 CLKs mid-line -> no state change.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture
//   Receiving end of a VGA output stream. Samples HSYNC/VSYNC/RGB on pixel
//   enables, measures line and frame timing, locks to the expected mode and
//   emits per-pixel X/Y/RGB strobes for the active area. It serves as a
//   loopback monitor for scan-converter self-test and as a bench checker.
//
//   Optional feature: define VGA_CAPTURE_CRC_EN to compute a CRC-16-CCITT
//   over each locked frame's active pixels. Without it FRAME_CRC and
//   CRC_VALID are tied to 0.
//
// Ports
//   CLK          system clock
//   nRESET       asynchronous active-low reset
//   PIX_en       pixel-rate enable; all sampling/counting only when high
//   VGA_HSYNC    horizontal sync, active high
//   VGA_VSYNC    vertical sync, active high
//   VGA_RGB      pixel colour {R,G,B}
//   PIX_X/PIX_Y  active-area column/row of the strobed pixel
//   PIX_RGB      captured colour of the strobed pixel
//   PIX_VALID    one-CLK strobe qualifying PIX_X/PIX_Y/PIX_RGB
//   LINE_LEN     last measured line length in samples
//   FRAME_LINES  last measured frame length in lines
//   LOCKED       timing matches H_TOTAL/V_TOTAL
//   SYNC_ERR     one-CLK strobe: timing violation while locked
//   FRAME_CRC    CRC of the last locked frame's active pixels
//   CRC_VALID    one-CLK strobe: FRAME_CRC updated
module vga_capture #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_START     = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_START     = 35,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        PIX_en,
    input  logic        VGA_HSYNC,
    input  logic        VGA_VSYNC,
    input  logic [2:0]  VGA_RGB,
    output logic [9:0]  PIX_X,
    output logic [9:0]  PIX_Y,
    output logic [2:0]  PIX_RGB,
    output logic        PIX_VALID,
    output logic [10:0] LINE_LEN,
    output logic [9:0]  FRAME_LINES,
    output logic        LOCKED,
    output logic        SYNC_ERR,
    output logic [15:0] FRAME_CRC,
    output logic        CRC_VALID
);

    localparam logic [11:0] H_TOTAL_W   = 12'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_W   = 11'(V_TOTAL);
    localparam logic [10:0] H_START_W   = 11'(H_START);
    localparam logic [10:0] H_END_W     = 11'(H_START + H_ACTIVE);
    localparam logic [9:0]  V_START_W   = 10'(V_START);
    localparam logic [9:0]  V_END_W     = 10'(V_START + V_ACTIVE);
    localparam logic [3:0]  LOCK_W      = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_TRACK,
        ST_LOCKED
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  good;
    logic [3:0]  good_next;
    logic [3:0]  good_inc;

    logic        hs_q;
    logic        vs_q;
    logic        hs_rise;
    logic        vs_rise;
    logic [10:0] hcnt;
    logic [10:0] hpos;
    logic [9:0]  vcnt;
    logic [9:0]  vpos;
    logic [9:0]  lcnt;
    logic [11:0] line_meas;
    logic [10:0] frame_meas;
    logic        err;
    logic        active;

    assign hs_rise = VGA_HSYNC & ~hs_q;
    assign vs_rise = VGA_VSYNC & ~vs_q;

    // Position of the current sample. hpos saturates so a lost hsync parks
    // the counter instead of wrapping into a plausible-looking position.
    always_comb begin
        hpos = hcnt;
        vpos = vcnt;
        if (hs_rise) begin
            hpos = '0;
        end else if (hcnt != 11'h7FF) begin
            hpos = hcnt + 11'd1;
        end
        if (vs_rise) begin
            vpos = '0;
        end else if (hs_rise && (vcnt != 10'h3FF)) begin
            vpos = vcnt + 10'd1;
        end
    end

    // Measurements are widened by one bit so saturated counters cannot
    // wrap into a value that happens to match the nominal timing.
    assign line_meas  = {1'b0, hcnt} + 12'd1;
    assign frame_meas = {1'b0, lcnt} + {10'b0, hs_rise};

    always_comb begin
        err = 1'b0;
        if (hs_rise && (line_meas != H_TOTAL_W)) err = 1'b1;
        if (vs_rise && (frame_meas != V_TOTAL_W)) err = 1'b1;
        if (hcnt == 11'h7FF) err = 1'b1;
    end

    // A sample that raises an error is never reported as a pixel.
    assign active = (state == ST_LOCKED) && !err &&
                    (hpos >= H_START_W) && (hpos < H_END_W) &&
                    (vpos >= V_START_W) && (vpos < V_END_W);

    assign good_inc = good + 4'd1;
    assign LOCKED   = (state == ST_LOCKED);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state <= ST_UNLOCKED;
            good  <= '0;
        end else begin
            state <= state_next;
            good  <= good_next;
        end
    end

    // Lock FSM: a VS rise starts tracking, LOCK_FRAMES clean frames lock,
    // any timing error drops back to UNLOCKED.
    always_comb begin
        state_next = state;
        good_next  = good;
        if (PIX_en) begin
            unique case (state)
                ST_UNLOCKED: begin
                    if (vs_rise) begin
                        state_next = ST_TRACK;
                        good_next  = '0;
                    end
                end
                ST_TRACK: begin
                    if (err) begin
                        state_next = ST_UNLOCKED;
                    end else if (vs_rise) begin
                        good_next = good_inc;
                        if (good_inc == LOCK_W) state_next = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (err) state_next = ST_UNLOCKED;
                end
                default: state_next = ST_UNLOCKED;
            endcase
        end
    end

    // Sync history, position counters, measurements and the pixel strobe.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            lcnt        <= '0;
            LINE_LEN    <= '0;
            FRAME_LINES <= '0;
            PIX_X       <= '0;
            PIX_Y       <= '0;
            PIX_RGB     <= '0;
            PIX_VALID   <= 1'b0;
            SYNC_ERR    <= 1'b0;
        end else begin
            PIX_VALID <= 1'b0;
            SYNC_ERR  <= 1'b0;
            if (PIX_en) begin
                hs_q <= VGA_HSYNC;
                vs_q <= VGA_VSYNC;
                hcnt <= hpos;
                vcnt <= vpos;
                if (vs_rise) begin
                    lcnt        <= '0;
                    FRAME_LINES <= 10'(frame_meas);
                end else if (hs_rise && (lcnt != 10'h3FF)) begin
                    lcnt <= lcnt + 10'd1;
                end
                if (hs_rise) LINE_LEN <= hcnt + 11'd1;
                if ((state == ST_LOCKED) && err) SYNC_ERR <= 1'b1;
                if (active) begin
                    PIX_VALID <= 1'b1;
                    PIX_X     <= 10'(hpos - H_START_W);
                    PIX_Y     <= vpos - V_START_W;
                    PIX_RGB   <= VGA_RGB;
                end
            end
        end
    end

`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] crc;

    // CRC-16-CCITT, MSB first, R bit shifted in first.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [2:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 2; i >= 0; i--) begin
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    // The running CRC restarts on every VS rise; it is only published for
    // frames that ended while locked.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            crc       <= 16'hFFFF;
            FRAME_CRC <= '0;
            CRC_VALID <= 1'b0;
        end else begin
            CRC_VALID <= 1'b0;
            if (PIX_en) begin
                if (vs_rise) begin
                    crc <= 16'hFFFF;
                    if (state == ST_LOCKED) begin
                        FRAME_CRC <= crc;
                        CRC_VALID <= 1'b1;
                    end
                end else if (active) begin
                    crc <= crc_step(crc, VGA_RGB);
                end
            end
        end
    end
`else
    assign FRAME_CRC = '0;
    assign CRC_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture
//   Scoreboard bench for vga_capture using a reduced 20x12 timing so that
//   several lock/unlock cycles fit in a short run. The driver pushes the
//   expected pixel for every active sample of a frame it expects to be
//   locked; a monitor pops and compares on each PIX_VALID strobe.
module tb_vga_capture;

    localparam int HT  = 20;
    localparam int VT  = 12;
    localparam int HSW = 4;
    localparam int HST = 4;
    localparam int HA  = 10;
    localparam int VST = 2;
    localparam int VA  = 6;
    localparam int LF  = 2;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] rgb;
    } pix_t;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic        PIX_en;
    logic        VGA_HSYNC;
    logic        VGA_VSYNC;
    logic [2:0]  VGA_RGB;
    logic [9:0]  PIX_X;
    logic [9:0]  PIX_Y;
    logic [2:0]  PIX_RGB;
    logic        PIX_VALID;
    logic [10:0] LINE_LEN;
    logic [9:0]  FRAME_LINES;
    logic        LOCKED;
    logic        SYNC_ERR;
    logic [15:0] FRAME_CRC;
    logic        CRC_VALID;

    pix_t        exp_q[$];
    logic [15:0] crc_log[$];
    int          cmp_count = 0;
    int          err_count = 0;
    int          strobe_count = 0;
    int          sync_err_count = 0;
    int          crc_valid_count = 0;
    int          lost_at;

    vga_capture #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HST), .H_ACTIVE(HA),
        .V_START(VST), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
    ) dut (
        .CLK(CLK), .nRESET(nRESET), .PIX_en(PIX_en),
        .VGA_HSYNC(VGA_HSYNC), .VGA_VSYNC(VGA_VSYNC), .VGA_RGB(VGA_RGB),
        .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIX_RGB(PIX_RGB), .PIX_VALID(PIX_VALID),
        .LINE_LEN(LINE_LEN), .FRAME_LINES(FRAME_LINES), .LOCKED(LOCKED),
        .SYNC_ERR(SYNC_ERR), .FRAME_CRC(FRAME_CRC), .CRC_VALID(CRC_VALID)
    );

    always #5 CLK = ~CLK;

    function automatic logic [2:0] rgb_for(input int h, input int v, input bit flip);
        if (flip && h == 10 && v == 2) return 3'd7;
        return 3'((h + 3 * v) % 8);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        cmp_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One pixel-enabled sample, driven on the falling edge.
    task automatic applyStimulus(input bit hs, input bit vs, input logic [2:0] rgb);
        @(negedge CLK);
        PIX_en    = 1'b1;
        VGA_HSYNC = hs;
        VGA_VSYNC = vs;
        VGA_RGB   = rgb;
    endtask

    // Five disabled CLKs with garbage on the sync/colour inputs.
    task automatic do_gap();
        @(posedge CLK);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            PIX_en    = 1'b0;
            VGA_HSYNC = 1'b1;
            VGA_VSYNC = 1'b1;
            VGA_RGB   = 3'd7;
            @(posedge CLK);
            #1;
            checkOutput("gap_pix_valid", PIX_VALID, 0);
        end
        checkOutput("gap_locked", LOCKED, 1);
        checkOutput("gap_line_len", LINE_LEN, HT);
    endtask

    // Asynchronous reset in the middle of a locked line.
    task automatic do_reset();
        @(posedge CLK);
        #3;
        nRESET = 1'b0;
        #1;
        checkOutput("rst_pix_valid", PIX_VALID, 0);
        checkOutput("rst_pix_x", PIX_X, 0);
        checkOutput("rst_pix_y", PIX_Y, 0);
        checkOutput("rst_pix_rgb", PIX_RGB, 0);
        checkOutput("rst_locked", LOCKED, 0);
        checkOutput("rst_line_len", LINE_LEN, 0);
        checkOutput("rst_frame_lines", FRAME_LINES, 0);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        nRESET = 1'b1;
    endtask

    task automatic send_frame(input bit locked_exp, input int short_line, input int gap_line,
                              input bit flip, input int reset_line);
        bit lk;
        int len;
        int exp_strobes;
        lk           = locked_exp;
        exp_strobes  = 0;
        strobe_count = 0;
        for (int v = 0; v < VT; v++) begin
            len = (v == short_line) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                if (v == gap_line && h == 8) do_gap();
                if (v == reset_line && h == 9) begin
                    do_reset();
                    lk = 1'b0;
                end
                applyStimulus(h < HSW, v < 2, rgb_for(h, v, flip));
                if (lk && h >= HST && h < HST + HA && v >= VST && v < VST + VA) begin
                    exp_q.push_back('{x: 10'(h - HST), y: 10'(v - VST), rgb: rgb_for(h, v, flip)});
                    exp_strobes++;
                end
                if (v == 0 && h == 0) begin
                    @(posedge CLK);
                    #1;
                    checkOutput("locked_at_vs", LOCKED, locked_exp);
                    if (locked_exp) checkOutput("frame_lines", FRAME_LINES, VT);
                end
                if (short_line >= 0 && v == short_line + 1 && h == 0) begin
                    @(posedge CLK);
                    #1;
                    checkOutput("short_sync_err", SYNC_ERR, 1);
                    checkOutput("short_line_len", LINE_LEN, HT - 1);
                    checkOutput("short_locked", LOCKED, 0);
                    lk = 1'b0;
                end
            end
        end
        @(negedge CLK);
        PIX_en = 1'b0;
        checkOutput("strobes_per_frame", strobe_count, exp_strobes);
    endtask

    // Monitor: pops one expected pixel per strobe and tallies event strobes.
    always begin
        pix_t e;
        @(posedge CLK);
        #1;
        if (PIX_VALID) begin
            strobe_count++;
            cmp_count++;
            if (exp_q.size() == 0) begin
                err_count++;
                $display("[TB] FAIL pix_unexpected: got x=%0d y=%0d rgb=%0d, expected no strobe",
                         PIX_X, PIX_Y, PIX_RGB);
            end else begin
                e = exp_q.pop_front();
                if (PIX_X !== e.x || PIX_Y !== e.y || PIX_RGB !== e.rgb) begin
                    err_count++;
                    $display("[TB] FAIL pix_data: got x=%0d y=%0d rgb=%0d, expected x=%0d y=%0d rgb=%0d",
                             PIX_X, PIX_Y, PIX_RGB, e.x, e.y, e.rgb);
                end
            end
        end
        if (SYNC_ERR) sync_err_count++;
        if (CRC_VALID) begin
            crc_valid_count++;
            crc_log.push_back(FRAME_CRC);
        end
    end

    initial begin
        nRESET    = 1'b0;
        PIX_en    = 1'b0;
        VGA_HSYNC = 1'b0;
        VGA_VSYNC = 1'b0;
        VGA_RGB   = 3'd0;
        #12;
        checkOutput("init_pix_valid", PIX_VALID, 0);
        checkOutput("init_locked", LOCKED, 0);
        checkOutput("init_line_len", LINE_LEN, 0);
        checkOutput("init_frame_lines", FRAME_LINES, 0);
        checkOutput("init_sync_err", SYNC_ERR, 0);
        @(negedge CLK);
        #1;
        nRESET = 1'b1;

        // Acquire lock: third VS rise locks.
        send_frame(1'b0, -1, -1, 1'b0, -1);
        send_frame(1'b0, -1, -1, 1'b0, -1);
        send_frame(1'b1, -1, -1, 1'b0, -1);
        // One 19-sample line breaks lock; relock takes three VS rises.
        send_frame(1'b1, 5, -1, 1'b0, -1);
        send_frame(1'b0, -1, -1, 1'b0, -1);
        send_frame(1'b0, -1, -1, 1'b0, -1);
        // Locked frames: a PIX_en gap, a repeat, and one flipped pixel.
        send_frame(1'b1, -1, 3, 1'b0, -1);
        send_frame(1'b1, -1, -1, 1'b0, -1);
        send_frame(1'b1, -1, -1, 1'b1, -1);
        // Mid-line reset, then relock from scratch.
        send_frame(1'b1, -1, -1, 1'b0, 4);
        send_frame(1'b0, -1, -1, 1'b0, -1);
        send_frame(1'b0, -1, -1, 1'b0, -1);
        send_frame(1'b1, -1, -1, 1'b0, -1);

        // Lost hsync: hcnt is 19 after the last line, so it reads 2047
        // on the 2029th following sample.
        lost_at = 0;
        for (int k = 1; k <= 2200 && lost_at == 0; k++) begin
            applyStimulus(1'b0, 1'b0, 3'd0);
            @(posedge CLK);
            #1;
            if (SYNC_ERR) lost_at = k;
        end
        checkOutput("lost_sync_sample", lost_at, 2029);
        checkOutput("lost_sync_locked", LOCKED, 0);
        checkOutput("lost_sync_line_len", LINE_LEN, HT);

        @(negedge CLK);
        PIX_en = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("sync_err_pulses", sync_err_count, 2);
        checkOutput("pending_pixels", exp_q.size(), 0);
`ifdef VGA_CAPTURE_CRC_EN
        checkOutput("crc_frames", crc_log.size(), 4);
        if (crc_log.size() == 4) begin
            checkOutput("crc_same_frame", crc_log[1], crc_log[0]);
            checkOutput("crc_repeat_frame", crc_log[2], crc_log[1]);
            cmp_count++;
            if (crc_log[3] == crc_log[2]) begin
                err_count++;
                $display("[TB] FAIL crc_flipped_pixel: got %0h, required a value other than %0h",
                         crc_log[3], crc_log[2]);
            end
        end
`else
        checkOutput("crc_valid_count", crc_valid_count, 0);
        checkOutput("frame_crc", FRAME_CRC, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
